// File: rtl/weight_bram_reader_pkg.sv
// Shared constants and types for the per-neuron weight BRAM reader.
package weight_bram_reader_pkg;

  localparam int unsigned ANN_DATA_W = 16;
  localparam int unsigned ANN_ADDR_W = 5;
  localparam int unsigned ANN_DEPTH  = 31;

  // Reader sweep state: IDLE waits for start, RUN issues reads, DRAIN empties the pipeline.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } reader_state_e;

endpackage

// File: rtl/weight_bram_reader_if.sv
// Weight stream from the reader to the neuron MAC (valid/ready).
interface weight_bram_reader_if
  import weight_bram_reader_pkg::*;
#(
  parameter int unsigned DATA_W = ANN_DATA_W,
  parameter int unsigned ADDR_W = ANN_ADDR_W
);

  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_last;
  logic              w_valid;
  logic              w_ready;

  modport master (
    output w_data,
    output w_idx,
    output w_last,
    output w_valid,
    input  w_ready
  );

  modport slave (
    input  w_data,
    input  w_idx,
    input  w_last,
    input  w_valid,
    output w_ready
  );

endinterface

// File: rtl/weight_bram_reader_skid_fifo.sv
// Two-entry synchronous FIFO buffering BRAM words ahead of the MAC; flush empties it in one cycle.
module weight_bram_reader_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // Popping an empty FIFO is ignored; a push into a full FIFO is only accepted alongside a pop.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy; flush wins over any simultaneous push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/weight_bram_reader.sv
// Sweeps one weight BRAM from address 0 to DEPTH-1 and streams the words to the neuron MAC.
module weight_bram_reader
  import weight_bram_reader_pkg::*;
#(
  parameter int unsigned DATA_W = ANN_DATA_W,
  parameter int unsigned ADDR_W = ANN_ADDR_W,
  parameter int unsigned DEPTH  = ANN_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  weight_bram_reader_if.master w
);

  // FIFO entry layout: {data, idx, last}.
  localparam int unsigned       EntryW  = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q;
  logic              done_q, done_d;
  logic              issue;
  logic              flush;
  logic              pop;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [EntryW-1:0] push_entry;
  logic [EntryW-1:0] head;

  // en_q doubles as the in-flight flag: a read registered last edge lands on this edge.
  // The word popped this cycle frees its slot, which keeps one word per cycle under w_ready=1
  // while still bounding FIFO plus in-flight words to two.
  assign pop        = w.w_valid && w.w_ready;
  assign occupancy  = 3'(fifo_count) + 3'(en_q) - 3'(pop);
  assign push_entry = {bram_do, addr_q, (addr_q == LastIdx)};

  // Next-state: sweep control, read issue and done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          flush   = 1'b1;
        end else if (occupancy < 3'd2) begin
          issue  = 1'b1;
          addr_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          flush   = 1'b1;
        end else if (pop && head[0]) begin
          // The last word is the final FIFO entry, so its handshake empties the pipeline.
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and BRAM command registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      en_q    <= issue;
      done_q  <= done_d;
    end
  end

  weight_bram_reader_skid_fifo #(
    .Width(EntryW)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .flush_i    (flush),
    .push_i     (en_q),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign bram_addr = addr_q;
  assign bram_en   = en_q;
  assign bram_we   = 1'b0;
  assign bram_di   = '0;

  assign w.w_valid = !fifo_empty;
  assign w.w_data  = head[EntryW-1 -: DATA_W];
  assign w.w_idx   = head[ADDR_W:1];
  assign w.w_last  = head[0];

endmodule

// File: tb/tb_weight_bram_reader.sv
// Self-checking bench for weight_bram_reader: DEPTH=31 instance plus a DEPTH=1 instance.
`timescale 1ns/1ps
module tb_weight_bram_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned D  = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, start1;
  logic          busy, done, bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di, bram_do;
  logic          busy1, done1, bram_en1, bram_we1;
  logic [AW-1:0] bram_addr1;
  logic [DW-1:0] bram_di1, bram_do1;

  weight_bram_reader_if #(.DATA_W(DW), .ADDR_W(AW)) wif ();
  weight_bram_reader_if #(.DATA_W(DW), .ADDR_W(AW)) wif1 ();

  weight_bram_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .CLK(clk), .RST(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_di(bram_di),
    .bram_do(bram_do), .w(wif)
  );

  weight_bram_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1)) dut1 (
    .CLK(clk), .RST(rst), .start(start1), .abort(1'b0), .busy(busy1), .done(done1),
    .bram_addr(bram_addr1), .bram_en(bram_en1), .bram_we(bram_we1), .bram_di(bram_di1),
    .bram_do(bram_do1), .w(wif1)
  );

  // Behavioural BRAMs: DO updates on the negedge after EN/ADDR are registered.
  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) mem0[bram_addr] <= bram_di;
      else         bram_do <= mem0[bram_addr];
    end
    if (bram_en1) begin
      if (bram_we1) mem1[bram_addr1] <= bram_di1;
      else          bram_do1 <= mem1[bram_addr1];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word i of a sweep is 0x0100+i at idx i, last only on i==D-1.
  logic sb_on = 1'b0;
  int   sb_idx = 0;
  int   rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: score the handshake about to happen, advance, then check stall/read rules.
  task automatic step();
    logic          quiet, hs, stalled, sl;
    logic [DW-1:0] sd;
    logic [AW-1:0] si;
    quiet   = rst || abort;
    hs      = wif.w_valid && wif.w_ready && !quiet;
    stalled = wif.w_valid && !wif.w_ready && !quiet;
    sd = wif.w_data;
    si = wif.w_idx;
    sl = wif.w_last;
    if (hs && sb_on) begin
      chk("sb_data", 32'(wif.w_data), 32'(16'h0100 + sb_idx));
      chk("sb_idx",  32'(wif.w_idx),  32'(sb_idx));
      chk("sb_last", 32'(wif.w_last), 32'(sb_idx == int'(D) - 1));
      sb_idx++;
    end
    @(posedge clk);
    #1;
    chk("we_zero", 32'({bram_we, bram_we1}), 32'd0);
    if (stalled) begin
      chk("stall_valid", 32'(wif.w_valid), 32'd1);
      chk("stall_hold", 32'({wif.w_data, wif.w_idx, wif.w_last}), 32'({sd, si, sl}));
    end
    if (bram_en && sb_on) begin
      chk("rd_addr", 32'(bram_addr), 32'(rd_cnt));
      rd_cnt++;
    end
    if (sb_on) chk("outstanding_le2", 32'((rd_cnt - sb_idx) <= 2), 32'd1);
  endtask

  task automatic pulse_start(input logic fresh);
    if (fresh) begin
      sb_on  = 1'b1;
      sb_idx = 0;
      rd_cnt = 0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input logic rnd);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (rnd) wif.w_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    if (done) begin
      chk({name, "_all_words"}, 32'(sb_idx), 32'(D));
      chk({name, "_idle_at_done"}, 32'(busy), 32'd0);
      wif.w_ready = 1'b1;
      step();
      chk({name, "_done_1cyc"}, 32'(done), 32'd0);
    end
    sb_on = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"},  32'(busy), 32'd0);
    chk({name, "_done"},  32'(done), 32'd0);
    chk({name, "_en"},    32'(bram_en), 32'd0);
    chk({name, "_addr"},  32'(bram_addr), 32'd0);
    chk({name, "_valid"}, 32'(wif.w_valid), 32'd0);
    chk({name, "_data"},  32'(wif.w_data), 32'd0);
    chk({name, "_idx"},   32'(wif.w_idx), 32'd0);
    chk({name, "_last"},  32'(wif.w_last), 32'd0);
  endtask

  // Timeline of a T1 sweep, k = clock edges after the one that samples start.
  typedef struct {
    int            k;
    logic          busy;
    logic          done;
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid, n;
    void'($urandom(32'd20240611));
    for (int i = 0; i < 2**AW; i++) begin
      mem0[i] = 16'h0100 + 16'(i);
      mem1[i] = 16'h0100 + 16'(i);
    end
    tbl[0] = '{0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 16'h0000, 1'b0};
    tbl[2] = '{2,  1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 16'h0100, 1'b0};
    tbl[3] = '{3,  1'b1, 1'b0, 1'b1, 5'd2,  1'b1, 16'h0101, 1'b0};
    tbl[4] = '{16, 1'b1, 1'b0, 1'b1, 5'd15, 1'b1, 16'h010E, 1'b0};
    tbl[5] = '{30, 1'b1, 1'b0, 1'b1, 5'd29, 1'b1, 16'h011C, 1'b0};
    tbl[6] = '{31, 1'b1, 1'b0, 1'b1, 5'd30, 1'b1, 16'h011D, 1'b0};
    tbl[7] = '{32, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 16'h011E, 1'b1};
    tbl[8] = '{33, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0};
    tbl[9] = '{34, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    wif.w_ready = 1'b1; wif1.w_ready = 1'b1;
    repeat (3) step();
    start = 1'b1;               // start together with RST: reset wins
    step();
    start = 1'b0;
    rst = 1'b0;
    chk_reset_outputs("reset");
    chk("reset_busy1", 32'(busy1), 32'd0);
    chk("reset_valid1", 32'(wif1.w_valid), 32'd0);
    step();
    chk("rst_beats_start", 32'(busy), 32'd0);

    // T1 (pass 0) and T5 (pass 1, extra start pulse while busy must change nothing).
    for (int pass = 0; pass < 2; pass++) begin
      nvalid = 0;
      pulse_start(1'b1);
      for (int k = 0; k <= 34; k++) begin
        if (k > 0) begin
          if (pass == 1 && k == 5) start = 1'b1;
          step();
          start = 1'b0;
        end
        if (k >= 2 && k <= 32 && wif.w_valid) nvalid++;
        for (int e = 0; e < 10; e++) begin
          if (tbl[e].k == k) begin
            chk($sformatf("t1p%0d_k%0d_busy", pass, k), 32'(busy), 32'(tbl[e].busy));
            chk($sformatf("t1p%0d_k%0d_done", pass, k), 32'(done), 32'(tbl[e].done));
            chk($sformatf("t1p%0d_k%0d_en", pass, k), 32'(bram_en), 32'(tbl[e].en));
            chk($sformatf("t1p%0d_k%0d_valid", pass, k), 32'(wif.w_valid), 32'(tbl[e].valid));
            if (tbl[e].en)
              chk($sformatf("t1p%0d_k%0d_addr", pass, k), 32'(bram_addr), 32'(tbl[e].addr));
            if (tbl[e].valid) begin
              chk($sformatf("t1p%0d_k%0d_data", pass, k), 32'(wif.w_data), 32'(tbl[e].data));
              chk($sformatf("t1p%0d_k%0d_last", pass, k), 32'(wif.w_last), 32'(tbl[e].last));
            end
          end
        end
      end
      chk($sformatf("t1p%0d_consecutive", pass), 32'(nvalid), 32'(D));
      chk($sformatf("t1p%0d_words", pass), 32'(sb_idx), 32'(D));
      sb_on = 1'b0;
    end

    // T2: random backpressure.
    pulse_start(1'b1);
    wait_done("t2", 3000, 1'b1);

    // T3: no ready until cycle 20.
    wif.w_ready = 1'b0;
    pulse_start(1'b1);
    for (int c = 1; c < 20; c++) step();
    chk("t3_two_reads", 32'(rd_cnt), 32'd2);
    chk("t3_en_idle", 32'(bram_en), 32'd0);
    chk("t3_valid_held", 32'(wif.w_valid), 32'd1);
    wif.w_ready = 1'b1;
    step();
    chk("t3_resume_en", 32'(bram_en), 32'd1);
    chk("t3_resume_addr", 32'(bram_addr), 32'd2);
    wait_done("t3", 200, 1'b0);

    // T4: abort after 10 words, then a fresh sweep.
    pulse_start(1'b1);
    n = 0;
    while (sb_idx < 10 && n < 100) begin step(); n++; end
    chk("t4_reached_word10", 32'(sb_idx), 32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    sb_on = 1'b0;
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_valid", 32'(wif.w_valid), 32'd0);
    chk("t4_en", 32'(bram_en), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("t4_no_done", 32'(done | wif.w_valid), 32'd0);
      step();
    end
    pulse_start(1'b1);
    step();
    chk("t4_restart_en", 32'(bram_en), 32'd1);
    chk("t4_restart_addr", 32'(bram_addr), 32'd0);
    wait_done("t4b", 100, 1'b0);

    // Abort together with start in IDLE: start wins.
    abort = 1'b1;
    pulse_start(1'b1);
    abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd1);
    wait_done("abort_start", 100, 1'b0);

    // T5b: RST at word 5 returns every output to its reset value.
    pulse_start(1'b1);
    n = 0;
    while (sb_idx < 5 && n < 100) begin step(); n++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_on = 1'b0;
    chk_reset_outputs("midrst");
    pulse_start(1'b1);
    wait_done("after_rst", 100, 1'b0);

    // T6: DEPTH=1 instance.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t6_k0_busy", 32'(busy1), 32'd1);
    chk("t6_k0_en", 32'(bram_en1), 32'd0);
    step();
    chk("t6_k1_en", 32'(bram_en1), 32'd1);
    chk("t6_k1_addr", 32'(bram_addr1), 32'd0);
    chk("t6_k1_valid", 32'(wif1.w_valid), 32'd0);
    step();
    chk("t6_k2_en", 32'(bram_en1), 32'd0);
    chk("t6_k2_valid", 32'(wif1.w_valid), 32'd1);
    chk("t6_k2_data", 32'(wif1.w_data), 32'h0100);
    chk("t6_k2_idx", 32'(wif1.w_idx), 32'd0);
    chk("t6_k2_last", 32'(wif1.w_last), 32'd1);
    chk("t6_k2_done", 32'(done1), 32'd0);
    step();
    chk("t6_k3_done", 32'(done1), 32'd1);
    chk("t6_k3_busy", 32'(busy1), 32'd0);
    chk("t6_k3_valid", 32'(wif1.w_valid), 32'd0);
    step();
    chk("t6_k4_done", 32'(done1), 32'd0);
    chk("t6_k4_en", 32'(bram_en1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
